// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-fetch handshake between the PC sequencer and instruction memory.
//   imem_req   : fetch request, driven by the sequencer
//   imem_addr  : fetch byte address, driven by the sequencer (equals pc)
//   imem_ack   : fetch complete, driven by the memory side
// The master modport is the sequencer side and the slave modport is the memory side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter unit with a request/acknowledge instruction-fetch handshake.
// The unit calculates sequential, branch, jump and jump-register targets.
// It buffers one pending redirect until the next completed fetch.
// All state changes happen on the falling edge of clk.
//
// Ports
//   clk              clock; state updates on negedge
//   rst_n            asynchronous active-low reset
//   run              global enable (0 = stall/hold)
//   redirect_valid   qualifies nPC_sel and the target inputs this cycle
//   nPC_sel          00 seq, 01 branch, 10 jump, 11 jump-register
//   imm              branch offset in words (sign-extended, then shifted left 2)
//   jtarget          jump word index
//   jr_addr          jump-register byte address
//   imem             fetch handshake (master side): imem_req, imem_addr, imem_ack
//   pc               current PC
//   pc_plus4         pc + INSTR_BYTES (combinational)
//   redirect_pending a redirect is latched and has not been applied yet
//   misaligned       sticky flag: a JR target had nonzero bits [1:0]
//
// Optional build macro: PC_SEQ_DELAY_SLOT_EN
//   When this macro is defined, a redirect uses branch-delay-slot semantics.
//   The first completed fetch after the redirect latches advances to pc_plus4.
//   The second completed fetch loads the target.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pc_sequencer #(
    parameter int          WIDTH       = 32,
    parameter int          IMM_W       = 16,
    parameter logic [31:0] RESET_PC    = 32'h0040_0020,
    parameter int          INSTR_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [1:0]        nPC_sel,
    input  logic [IMM_W-1:0]  imm,
    input  logic [25:0]       jtarget,
    input  logic [WIDTH-1:0]  jr_addr,
    pc_sequencer_if.master    imem,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus4,
    output logic              redirect_pending,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP           = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(RESET_PC);
    // The jump target replaces the low 28 bits and keeps the region bits of pc_plus4.
    localparam logic [WIDTH-1:0] JUMP_LOW_MASK  = WIDTH'(28'hFFF_FFFF);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] target_reg;
    logic             pending_reg;
    logic             req_reg;
    logic             mis_reg;
`ifdef PC_SEQ_DELAY_SLOT_EN
    // Set when the delay-slot fetch of the pending redirect has completed.
    logic             slot_done_reg;
`endif

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] target_next;
    logic             redirect_new;
    logic             completion;

    assign pc_plus4 = pc_reg + STEP;
    assign imm_ext  = {{(WIDTH-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};

    always_comb begin
        target_next = pc_plus4;
        case (nPC_sel)
            2'b01:   target_next = pc_plus4 + imm_ext;
            2'b10:   target_next = (pc_plus4 & ~JUMP_LOW_MASK) | WIDTH'({jtarget, 2'b00});
            2'b11:   target_next = {jr_addr[WIDTH-1:2], 2'b00};
            default: target_next = pc_plus4;
        endcase
    end

    assign redirect_new = redirect_valid && (nPC_sel != 2'b00);
    // A fetch completes on any ack that is seen in FETCH, also when run drops on that same edge.
    assign completion   = (state_reg == FETCH) && imem.imem_ack;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_VALUE;
            target_reg    <= '0;
            pending_reg   <= 1'b0;
            req_reg       <= 1'b0;
            mis_reg       <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            slot_done_reg <= 1'b0;
`endif
        end else begin
            if (redirect_new && (nPC_sel == 2'b11) && (jr_addr[1:0] != 2'b00))
                mis_reg <= 1'b1;

            // Control state. The request is a registered copy of "in FETCH".
            case (state_reg)
                BOOT, HOLD: begin
                    state_reg <= run ? FETCH : HOLD;
                    req_reg   <= run;
                end
                FETCH: begin
                    state_reg <= run ? FETCH : HOLD;
                    req_reg   <= run;
                end
                default: begin
                    state_reg <= BOOT;
                    req_reg   <= 1'b0;
                end
            endcase

            // PC advance and redirect bookkeeping
`ifdef PC_SEQ_DELAY_SLOT_EN
            if (completion) begin
                if (pending_reg && slot_done_reg) begin
                    // The slot has already been used. The latest target goes to the PC now.
                    pc_reg        <= redirect_new ? target_next : target_reg;
                    pending_reg   <= 1'b0;
                    slot_done_reg <= 1'b0;
                end else begin
                    // This completion is the delay slot.
                    pc_reg <= pc_plus4;
                    if (redirect_new) begin
                        target_reg    <= target_next;
                        pending_reg   <= 1'b1;
                        slot_done_reg <= 1'b1;
                    end else if (pending_reg) begin
                        slot_done_reg <= 1'b1;
                    end
                end
            end else if (redirect_new) begin
                target_reg  <= target_next;
                pending_reg <= 1'b1;
                // Overwriting an in-flight redirect keeps its slot progress.
                if (!pending_reg)
                    slot_done_reg <= 1'b0;
            end
`else
            if (completion) begin
                // A redirect on the same edge as the ack takes priority over an older pending target.
                if (redirect_new)
                    pc_reg <= target_next;
                else if (pending_reg)
                    pc_reg <= target_reg;
                else
                    pc_reg <= pc_plus4;
                pending_reg <= 1'b0;
            end else if (redirect_new) begin
                target_reg  <= target_next;
                pending_reg <= 1'b1;
            end
`endif
        end
    end

    assign pc               = pc_reg;
    assign imem.imem_req    = req_reg;
    assign imem.imem_addr   = pc_reg;
    assign redirect_pending = pending_reg;
    assign misaligned       = mis_reg;

endmodule
